cpu_sequencer: RTL

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_sequencer_pkg.sv | 58 +++++
 rtl/cpu_sequencer_if.sv | 22 ++
 rtl/cpu_sequencer_cond_check.sv | 38 +++
 rtl/cpu_sequencer.sv | 132 +++++++++++++
 4 files changed

// File: rtl/cpu_sequencer_pkg.sv
// Shared definitions for the CPU sequencer: FSM state encoding, opcodes,
// condition codes, instruction-register field positions and flag bits.
// Optional SEQ_STEP_EN adds the PAUSE state used for single-stepping.
package cpu_pkg;

    // Instruction register field positions
    localparam int IR_COND_HI = 31;
    localparam int IR_COND_LO = 28;
    localparam int IR_OP_HI   = 27;
    localparam int IR_OP_LO   = 24;
    localparam int IR_S_BIT   = 23;
    localparam int IR_RD_HI   = 22;
    localparam int IR_RD_LO   = 19;

    // Flag register bit positions, {N,Z,C,V}
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Opcodes the sequencer treats specially; every other value is an ALU op
    localparam logic [3:0] OP_LDR  = 4'hD;
    localparam logic [3:0] OP_STR  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    // ARM-style condition codes
    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEM       = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_HALT      = 3'd6
`ifdef SEQ_STEP_EN
        ,
        ST_PAUSE     = 3'd7
`endif
    } state_t;

endpackage

// File: rtl/cpu_sequencer_if.sv
// RAM / ALU / register-bank signals between the sequencer and its datapath.
interface cpu_sequencer_if;
    logic        Ram_Enable;
    logic        Ram_RW;
    logic [15:0] Ram_Address;
    logic [31:0] Ram_Out;
    logic [31:0] Instr;
    logic [31:0] Alu_Result;
    logic [3:0]  New_Flag;
    logic [3:0]  Flag;
    logic        Reg_We;

    modport master (
        output Ram_Enable, Ram_RW, Ram_Address, Instr, Flag, Reg_We,
        input  Ram_Out, Alu_Result, New_Flag
    );

    modport slave (
        input  Ram_Enable, Ram_RW, Ram_Address, Instr, Flag, Reg_We,
        output Ram_Out, Alu_Result, New_Flag
    );
endinterface

// File: rtl/cpu_sequencer_cond_check.sv
// Combinational ARM condition evaluation: Cond field against {N,Z,C,V}.
module cond_check
    import cpu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flag,
    output logic       pass
);
    logic n, z, c, v;

    assign n = flag[FLAG_N];
    assign z = flag[FLAG_Z];
    assign c = flag[FLAG_C];
    assign v = flag[FLAG_V];

    // Map each condition code to its flag predicate; NV never passes
    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = ~z;
            COND_CS: pass = c;
            COND_CC: pass = ~c;
            COND_MI: pass = n;
            COND_PL: pass = ~n;
            COND_VS: pass = v;
            COND_VC: pass = ~v;
            COND_HI: pass = c & ~z;
            COND_LS: pass = ~c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = ~z & (n == v);
            COND_LE: pass = z | (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end
endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle CPU control sequencer: FETCH -> DECODE -> EXECUTE ->
// (MEM) -> WRITEBACK, with condition-fail short cut, HALT and PC wrap.
// Strobes are decoded from the state register so reset drops them at once.
// Optional macro SEQ_STEP_EN: adds Step input and PAUSE state between
// instructions for single-stepping.
module cpu_sequencer
    import cpu_pkg::*;
(
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic                   Start,
`ifdef SEQ_STEP_EN
    input  logic                   Step,
`endif
    cpu_sequencer_if.master        bus,
    output logic [7:0]             Pc,
    output logic                   Busy,
    output logic                   Halted
);

`ifdef SEQ_STEP_EN
    localparam state_t ST_RETIRE = ST_PAUSE;
`else
    localparam state_t ST_RETIRE = ST_FETCH;
`endif

    state_t      state, state_nxt;
    logic [31:0] ir;
    logic [3:0]  flag_q;
    logic [7:0]  pc_q;

    logic [3:0]  cond, opcode, rd;
    logic        s_bit, is_mem, cond_pass;
    logic        unused_bits;

    assign cond   = ir[IR_COND_HI:IR_COND_LO];
    assign opcode = ir[IR_OP_HI:IR_OP_LO];
    assign s_bit  = ir[IR_S_BIT];
    assign rd     = ir[IR_RD_HI:IR_RD_LO];
    assign is_mem = (opcode == OP_LDR) || (opcode == OP_STR);

    // Destination and the upper address bits belong to the datapath
    assign unused_bits = ^{rd, ir[18:0], bus.Alu_Result[31:16]};

    cond_check u_cond (
        .cond (cond),
        .flag (flag_q),
        .pass (cond_pass)
    );

    // Next-state selection
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:      if (Start) state_nxt = ST_FETCH;
            ST_FETCH:     state_nxt = ST_DECODE;
            ST_DECODE:    state_nxt = ST_EXECUTE;
            ST_EXECUTE: begin
                if (!cond_pass)              state_nxt = ST_RETIRE;
                else if (opcode == OP_HALT)  state_nxt = ST_HALT;
                else if (is_mem)             state_nxt = ST_MEM;
                else                         state_nxt = ST_WRITEBACK;
            end
            ST_MEM:       state_nxt = ST_WRITEBACK;
            ST_WRITEBACK: state_nxt = ST_RETIRE;
            ST_HALT:      state_nxt = ST_HALT;
`ifdef SEQ_STEP_EN
            ST_PAUSE:     if (Step) state_nxt = ST_FETCH;
`endif
            default:      state_nxt = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // Program counter: cleared on Start, advanced on retire (pass or fail)
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            pc_q <= 8'h00;
        else if (state == ST_IDLE && Start)
            pc_q <= 8'h00;
        else if ((state == ST_EXECUTE && !cond_pass) || state == ST_WRITEBACK)
            pc_q <= pc_q + 8'h01;
    end

    // Instruction register loads RAM data one cycle after the fetch strobe
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)                ir <= 32'h0;
        else if (state == ST_DECODE) ir <= bus.Ram_Out;
    end

    // Flags update only for flag-setting ALU ops at writeback
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            flag_q <= 4'b0000;
        else if (state == ST_WRITEBACK && s_bit && !is_mem)
            flag_q <= bus.New_Flag;
    end

    // RAM and register-bank strobes decoded from the current state
    always_comb begin
        bus.Ram_Enable  = 1'b0;
        bus.Ram_RW      = 1'b0;
        bus.Ram_Address = 16'h0000;
        bus.Reg_We      = 1'b0;
        case (state)
            ST_FETCH: begin
                bus.Ram_Enable  = 1'b1;
                bus.Ram_RW      = 1'b1;
                bus.Ram_Address = {8'h00, pc_q};
            end
            ST_MEM: begin
                bus.Ram_Enable  = 1'b1;
                bus.Ram_RW      = (opcode == OP_LDR);
                bus.Ram_Address = bus.Alu_Result[15:0];
            end
            ST_WRITEBACK: bus.Reg_We = (opcode != OP_STR);
            default: ;
        endcase
    end

    assign bus.Instr = ir;
    assign bus.Flag  = flag_q;
    assign Pc        = pc_q;
    assign Busy      = (state != ST_IDLE) && (state != ST_HALT);
    assign Halted    = (state == ST_HALT);

endmodule
